am_tx_1b: RTL and testbench
===========================

# am_tx_1b

1-bit AM transmitter, the transmit-direction counterpart of the comparator/NCO/mixer/CIC/AM-demod receive chain. Accepts 16-bit signed audio samples over a valid/ready handshake and holds each one for a fixed number of clocks (zero-order hold). Amplitude-modulates an NCO cosine carrier with the held sample. Converts the modulated carrier to a single-bit RF drive with a first-order sigma-delta modulator. Sits beside the receive path on the same PLL clock and drives an output pin through an external reconstruction filter.

## Interface
- RATE_DIV, 1024, clocks per audio sample; range 2..65536; about 24.5 kHz at 25.125 MHz.
- PHASE_W, 40, NCO phase accumulator width.
- clk  in  1  system clock, the PLL output.
- RST  in  1  reset; synchronous, active-high.
- tx_en  in  1  transmit enable.
- phase_inc  in  PHASE_W  carrier tuning word, sampled every cycle.
- mod_depth  in  8  modulation index; value/256. Sampled at each rate tick.
- audio_in  in  16  signed audio sample.
- audio_valid  in  1  audio_in is valid.
- audio_ready  out  1  holding buffer is empty; the block can accept a sample.
- underrun  out  1  one-cycle pulse: a rate tick found no buffered sample.
- rf_out  out  1  sigma-delta RF bitstream.

## Operation
- **Rate counter.** Counts 0..RATE_DIV-1 and wraps. tick = (count == RATE_DIV-1).
- **Holding buffer.**
  - One entry. audio_ready = !full.
  - A sample is accepted when audio_valid && audio_ready; full sets on the next edge.
  - At tick with full=1: cur_sample <= buffer and full clears.
  - At tick with full=0: cur_sample is unchanged and underrun pulses.
  - Accept and tick in the same cycle with full=0: the sample enters the buffer, underrun still pulses, and cur_sample is unchanged.
  - While full=1, audio_ready is low, so a new sample is never accepted in a tick cycle that drains the buffer.
- **Envelope.** Registered on the cycle after tick: env = 32768 + ((cur_sample * depth_latched) >>> 8).
  - Arithmetic right shift; unsigned 16-bit result.
  - Range 128..65407, so it never wraps.
  - depth_latched is mod_depth captured at tick.
- **NCO.** phase <= phase + phase_inc, wrapping mod 2^PHASE_W.
  - The existing 1024-entry cosine table is read at address phase[PHASE_W-1:PHASE_W-10].
  - The table output is 16-bit signed with a one-cycle read latency.
- **Mixer.** prod = env (unsigned 16) * cos (signed 16), formed as a signed 33-bit product.
  - x = prod[31:16], signed 16.
  - No overflow is possible: |prod| < 2^31.
- **Sigma-delta.**
  - Error register e, signed 18-bit.
  - v = e + x.
  - rf_out <= (v >= 0).
  - e <= v - (v >= 0 ? 32767 : -32768).
  - |e| stays ≤ 32768, so e never saturates.
- **tx_en = 0.**
  - phase, e and rf_out are held at 0.
  - The buffer, rate counter and underrun keep running, so audio flow control is unaffected.
  - When tx_en rises, phase starts at 0 on the next cycle.

## Timing
- **Reset values:**
  - rf_out = 0, audio_ready = 1, underrun = 0.
  - phase = 0, e = 0, count = 0, full = 0.
  - cur_sample = 0, env = 32768, depth_latched = 0.
- **Carrier path latency:**
  - phase register at cycle n.
  - cos at n+1.
  - x registered at n+2.
  - rf_out at n+3.
- **Audio-to-envelope latency:** env updates 1 cycle after the consuming tick, and reaches rf_out 2 cycles later.
- **First tick:** first tick after reset is at cycle RATE_DIV-1.
- **RST mid-operation:** a sample in the buffer is discarded. audio_ready returns to 1 on the cycle after RST is sampled high.
- **underrun:** is exactly one cycle wide, coincident with the registered output of the tick cycle.
- **phase_inc changes:** take effect on the next accumulate, and are phase-continuous.

## Test plan
- **Reset and enable gating.** Assert RST for 3 cycles with tx_en=1, then hold tx_en=0 for 100 cycles.
  - Required: rf_out=0, audio_ready=1, underrun=0 throughout.
- **DC carrier.** phase_inc=0, depth=0, tx_en=1, no audio.
  - x=16383 constant.
  - Ones count in rf_out over 4096 cycles, after 8 warm-up cycles, must be 3072±2.
- **Quarter-rate carrier.** phase_inc=2^38, depth=0.
  - x cycles through ≈16383, 0, -16384, 0.
  - Ones count over 4096 cycles must be 2048±4.
  - The pattern repeats with period 4 after settling.
- **Handshake.** RATE_DIV=4; drive audio_valid continuously with values 100, 200, 300.
  - audio_ready must drop the cycle after each accept and rise the cycle after each tick.
  - cur_sample must take 100, then 200, then 300 on successive ticks.
  - No underrun while the source keeps up.
- **Underrun.** RATE_DIV=4; supply one sample and then stop.
  - underrun pulses on every tick after the first consuming tick.
  - env stays at the last value.
  - Also cover a sample arriving exactly in a tick cycle with the buffer empty: underrun still pulses, and the sample is consumed at the following tick.
- **Full-scale envelope.** depth=255.
  - audio=32767 gives env=65407.
  - audio=-32768 gives env=128.
  - In both cases, with phase_inc=0, the ones density must match (x+32768)/65535 within ±2 counts per 4096 cycles.

Source files
------------

// File: rtl/am_tx_1b.sv
// 1-bit AM transmitter: zero-order-hold audio, NCO cosine carrier, envelope mixer,
// first-order sigma-delta to a single RF output bit.
module am_tx_1b #(
  parameter int RATE_DIV = 1024,
  parameter int PHASE_W  = 40
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               tx_en,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [7:0]         mod_depth,
  input  logic [15:0]        audio_in,
  input  logic               audio_valid,
  output logic               audio_ready,
  output logic               underrun,
  output logic               rf_out
);

  localparam int CNT_W = $clog2(RATE_DIV);

  // Quarter-wave cosine, 257 points over [0, pi/2], scaled by 32767. Built at
  // elaboration with a fixed-point Taylor series (Q30, terms through t^5).
  typedef logic [256:0][15:0] qtab_t;

  function automatic qtab_t gen_qtab();
    qtab_t  t;
    longint one, th, tt, r;
    t   = '0;
    one = 64'sd1073741824;
    for (int k = 0; k <= 256; k++) begin
      th = longint'(k) * 64'sd6588397;
      tt = (th * th) >>> 30;
      r  = one - tt / 90;
      r  = one - ((tt * r) >>> 30) / 56;
      r  = one - ((tt * r) >>> 30) / 30;
      r  = one - ((tt * r) >>> 30) / 12;
      r  = one - ((tt * r) >>> 30) / 2;
      t[k] = 16'((r * 32767 + (64'sd1 <<< 29)) >>> 30);
    end
    return t;
  endfunction

  localparam qtab_t QTAB = gen_qtab();

  logic [CNT_W-1:0]   count;
  logic               tick, tick_d, full, accept;
  logic [15:0]        hold_q;
  logic signed [15:0] cur_sample;
  logic [7:0]         depth_latched;
  logic [15:0]        env;
  logic [PHASE_W-1:0] phase;
  logic signed [15:0] cos_q, cos_d, x_q;
  logic signed [17:0] e, v;
  logic               v_pos;
  logic [1:0]         quad;
  logic [7:0]         idx;
  logic [8:0]         qa;
  logic signed [24:0] env_prod;
  logic signed [32:0] prod;

  assign tick        = (count == CNT_W'(RATE_DIV - 1));
  assign audio_ready = !full;
  assign accept      = audio_valid && audio_ready;

  assign env_prod = cur_sample * $signed({1'b0, depth_latched});
  assign prod     = $signed({1'b0, env}) * cos_q;
  assign v        = e + {{2{x_q[15]}}, x_q};
  assign v_pos    = !v[17];

  // Fold the 10-bit address onto the quarter table; quadrants 1 and 2 negate.
  assign quad = phase[PHASE_W-1 -: 2];
  assign idx  = phase[PHASE_W-3 -: 8];

  always_comb begin
    qa    = quad[0] ? (9'd256 - {1'b0, idx}) : {1'b0, idx};
    cos_d = $signed(QTAB[qa]);
    if (quad[0] ^ quad[1]) cos_d = -$signed(QTAB[qa]);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      count         <= '0;
      full          <= 1'b0;
      hold_q        <= '0;
      cur_sample    <= '0;
      depth_latched <= '0;
      tick_d        <= 1'b0;
      underrun      <= 1'b0;
      env           <= 16'd32768;
      phase         <= '0;
      cos_q         <= '0;
      x_q           <= '0;
      e             <= '0;
      rf_out        <= 1'b0;
    end else begin
      count <= tick ? '0 : count + CNT_W'(1);
      if (accept) hold_q <= audio_in;
      // An accept can only coincide with a tick while empty, so accept wins.
      if (accept)    full <= 1'b1;
      else if (tick) full <= 1'b0;
      if (tick && full) cur_sample <= $signed(hold_q);
      if (tick) depth_latched <= mod_depth;
      underrun <= tick && !full;
      tick_d   <= tick;
      // Result lies in 128..65407, so adding 32768 mod 2^16 is exact.
      if (tick_d) env <= 16'(env_prod >>> 8) + 16'h8000;
      cos_q <= cos_d;
      x_q   <= 16'(prod >>> 16);
      if (tx_en) begin
        phase  <= phase + phase_inc;
        e      <= v_pos ? (v - 18'sd32767) : (v + 18'sd32768);
        rf_out <= v_pos;
      end else begin
        phase  <= '0;
        e      <= '0;
        rf_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_am_tx_1b.sv
// Bench for am_tx_1b: carrier density on a RATE_DIV=1024 instance, audio handshake,
// underrun and full-scale envelope on a RATE_DIV=4 instance, scoreboarded consumption.
module tb_am_tx_1b;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        tx_en_a = 1'b1, tx_en_b = 1'b0;
  logic [39:0] phase_inc_a = '0, phase_inc_b = '0;
  logic [7:0]  mod_depth_b = '0;
  logic [15:0] audio_in_b = '0;
  logic        audio_valid_b = 1'b0;
  logic        ready_a, underrun_a, rf_a;
  logic        ready_b, underrun_b, rf_b;

  always #5 clk = ~clk;

  am_tx_1b #(.RATE_DIV(1024), .PHASE_W(40)) dut_a (
    .clk(clk), .RST(RST), .tx_en(tx_en_a), .phase_inc(phase_inc_a), .mod_depth(8'd0),
    .audio_in(16'd0), .audio_valid(1'b0), .audio_ready(ready_a), .underrun(underrun_a),
    .rf_out(rf_a));

  am_tx_1b #(.RATE_DIV(4), .PHASE_W(40)) dut_b (
    .clk(clk), .RST(RST), .tx_en(tx_en_b), .phase_inc(phase_inc_b), .mod_depth(mod_depth_b),
    .audio_in(audio_in_b), .audio_valid(audio_valid_b), .audio_ready(ready_b),
    .underrun(underrun_b), .rf_out(rf_b));

  typedef struct { logic signed [15:0] smp; int env; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int kcnt = 0, urun_cnt = 0;
  logic rst_q = 1'b1;

  // Edges since reset release; the RATE_DIV=4 instance ticks on every 4th one.
  always @(posedge clk) begin
    kcnt  <= RST ? 0 : kcnt + 1;
    rst_q <= RST;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Monitor: a rising audio_ready outside reset means a tick consumed the buffer.
  initial begin
    logic rdy_prev;
    bit   tick_seen;
    exp_t ex;
    rdy_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        urun_cnt = 0;
        rdy_prev = ready_b;
      end else begin
        tick_seen = (kcnt != 0) && (kcnt % 4 == 0);
        if (underrun_b) begin
          urun_cnt++;
          chk("underrun_on_tick", int'(tick_seen), 1);
        end
        if (ready_b && !rdy_prev) begin
          chk("ready_rise_on_tick", int'(tick_seen), 1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_consume actual=unexpected_consume required=queued_sample");
          end else begin
            ex = exp_q.pop_front();
            chk("cur_sample", int'(dut_b.cur_sample), int'(ex.smp));
            @(negedge clk);
            chk("env", int'(dut_b.env), ex.env);
          end
        end
        rdy_prev = ready_b;
      end
    end
  end

  task automatic send(input logic [15:0] s, input int exp_env, input bit push);
    int w = 0;
    audio_in_b = s; audio_valid_b = 1'b1;
    while (!ready_b && w < 40) begin @(negedge clk); w++; end
    if (w >= 40) chk("send_timeout", 0, 1);
    else begin
      if (push) exp_q.push_back('{smp: s, env: exp_env});
      @(negedge clk);
      chk("ready_drop_after_accept", int'(ready_b), 0);
    end
    audio_valid_b = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 50) begin @(negedge clk); w++; end
    chk("sb_drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic measure(input bit sel, output int ones, output int pbad);
    bit h [4096];
    ones = 0; pbad = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      h[i] = sel ? rf_b : rf_a;
      ones += int'(h[i]);
      if (i >= 4 && h[i] != h[i-4]) pbad++;
    end
  endtask

  task automatic restart(input bit sel);
    if (sel) tx_en_b = 1'b0; else tx_en_a = 1'b0;
    repeat (3) @(negedge clk);
    if (sel) tx_en_b = 1'b1; else tx_en_a = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, pbad, w;
    // Reset with tx_en high, then 100 cycles disabled.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rf_a", int'(rf_a), 0);
      chk("rst_ready_a", int'(ready_a), 1);
      chk("rst_underrun_a", int'(underrun_a), 0);
    end
    chk("rst_ready_b", int'(ready_b), 1);
    chk("rst_rf_b", int'(rf_b), 0);
    chk("rst_env_b", int'(dut_b.env), 32768);
    chk("rst_cur_b", int'(dut_b.cur_sample), 0);
    RST = 1'b0; tx_en_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("dis_rf_a", int'(rf_a), 0);
      chk("dis_ready_a", int'(ready_a), 1);
      chk("dis_underrun_a", int'(underrun_a), 0);
    end

    // DC carrier: x = 16383, density 3/4.
    tx_en_a = 1'b1;
    repeat (8) @(negedge clk);
    measure(1'b0, ones, pbad);
    chk_rng("dc_ones", ones, 3070, 3074);

    // Quarter-rate carrier: x = 16383, 0, -16384, 0.
    phase_inc_a = 40'h40_0000_0000;
    restart(1'b0);
    measure(1'b0, ones, pbad);
    chk_rng("quarter_ones", ones, 2044, 2052);
    chk("quarter_period4_breaks", pbad, 0);

    // Handshake on the RATE_DIV=4 instance.
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    exp_q.delete();
    mod_depth_b = 8'd128;
    send(16'd100, 32818, 1'b1);
    send(16'd200, 32868, 1'b1);
    send(16'd300, 32918, 1'b1);
    #1 chk("no_underrun_handshake", urun_cnt, 0);

    // Source stops: ticks 12 (consume 300), 16, 20, 24 (underrun).
    repeat (16) @(negedge clk);
    #1 chk("underrun_count", urun_cnt, 3);
    chk("env_held", int'(dut_b.env), 32918);

    // Sample lands exactly on a tick while empty.
    w = 0;
    while (kcnt % 4 != 3 && w < 8) begin @(negedge clk); w++; end
    audio_in_b = 16'd400; audio_valid_b = 1'b1;
    exp_q.push_back('{smp: 16'sd400, env: 32968});
    @(negedge clk);
    audio_valid_b = 1'b0;
    chk("arrival_tick_underrun", int'(underrun_b), 1);
    chk("arrival_tick_ready", int'(ready_b), 0);
    wait_drain();

    // Full-scale envelope, positive and negative.
    mod_depth_b = 8'd255;
    send(16'h7fff, 65407, 1'b1);
    wait_drain();
    restart(1'b1);
    measure(1'b1, ones, pbad);
    chk_rng("fs_pos_ones", ones, 4090, 4094);
    send(16'h8000, 128, 1'b1);
    wait_drain();
    restart(1'b1);
    measure(1'b1, ones, pbad);
    chk_rng("fs_neg_ones", ones, 2050, 2054);

    // Reset with a sample buffered: it is discarded.
    tx_en_b = 1'b0;
    send(16'd555, 0, 1'b0);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    chk("ready_after_rst", int'(ready_b), 1);
    chk("cur_after_rst", int'(dut_b.cur_sample), 0);
    repeat (9) @(negedge clk);
    #1 chk("underrun_after_rst", urun_cnt, 2);
    chk("env_after_rst", int'(dut_b.env), 32768);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
